// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus hazard control (load-use, single-entry long-latency scoreboard, watchdog).
// Optional stall counter output is enabled by defining HAZARD_STALL_CNT_EN.
module fwd_hazard_unit #(
    parameter int REG_AW         = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = 2,
    parameter int MC_TIMEOUT     = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [NUM_FWD_STAGES-1:0]   st_regwrite,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] st_rd,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic                        id_mc_issue,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        ex_memread,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        mc_done,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic                        mc_busy,
    output logic                        mc_timeout
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int CNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg, state_next;
    logic [REG_AW-1:0]  mc_rd_reg, mc_rd_next;
    logic [CNT_W-1:0]   mc_cnt_reg, mc_cnt_next;
    logic               timeout_reg, timeout_next;

    logic [NUM_SRC-1:0] lu_hit;
    logic [NUM_SRC-1:0] busy_hit;
    logic               load_use;
    logic               busy_stall;
    logic               hazard;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [SEL_W-1:0] sel;

            // Walk oldest to youngest so the youngest matching stage wins.
            always_comb begin
                sel = '0;
                for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                    if (st_regwrite[k] && (st_rd[k*REG_AW +: REG_AW] != '0) &&
                        (st_rd[k*REG_AW +: REG_AW] == ex_rs[gi*REG_AW +: REG_AW]))
                        sel = SEL_W'(k + 1);
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = rst ? '0 : sel;
            assign lu_hit[gi]   = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
            assign busy_hit[gi] = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == mc_rd_reg);
        end
    endgenerate

    assign load_use   = id_valid && ex_memread && (ex_rd != '0) && (|lu_hit);
    assign busy_stall = (state_reg == BUSY) && id_valid &&
                        (((mc_rd_reg != '0) && (|busy_hit)) || id_mc_issue);
    assign hazard     = load_use || busy_stall;

    assign stall      = !rst && hazard;
    assign bubble     = !rst && hazard;
    assign mc_busy    = (state_reg == BUSY);
    assign mc_timeout = timeout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mc_rd_reg   <= '0;
            mc_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mc_rd_reg   <= mc_rd_next;
            mc_cnt_reg  <= mc_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mc_rd_next   = mc_rd_reg;
        mc_cnt_next  = mc_cnt_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (id_valid && id_mc_issue && !hazard) begin
                    state_next  = BUSY;
                    mc_rd_next  = id_rd;
                    mc_cnt_next = '0;
                end
            end
            BUSY: begin
                // Completion takes precedence over a coincident timeout.
                if (mc_done) begin
                    state_next = IDLE;
                end else if (mc_cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    mc_cnt_next = mc_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: vector table for the
// combinational paths, hand-written sequences for scoreboard, timeout and reset.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ex_rs;
    logic [1:0]  st_regwrite;
    logic [9:0]  st_rd;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_mc_issue;
    logic [4:0]  id_rd;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mc_done;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        bubble;
    logic        mc_busy;
    logic        mc_timeout;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_rs       (ex_rs),
        .st_regwrite (st_regwrite),
        .st_rd       (st_rd),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_mc_issue (id_mc_issue),
        .id_rd       (id_rd),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mc_done     (mc_done),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .bubble      (bubble),
        .mc_busy     (mc_busy),
        .mc_timeout  (mc_timeout)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [9:0] ex_rs;
        logic [1:0] st_regwrite;
        logic [9:0] st_rd;
        logic       id_valid;
        logic [9:0] id_rs;
        logic [1:0] id_rs_used;
        logic       ex_memread;
        logic [4:0] ex_rd;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic clear_inputs();
        ex_rs = '0; st_regwrite = '0; st_rd = '0; id_valid = 1'b0; id_rs = '0;
        id_rs_used = '0; id_mc_issue = 1'b0; id_rd = '0; ex_memread = 1'b0;
        ex_rd = '0; mc_done = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //            name          ex_rs          we     st_rd {st1,st0}  idv id_rs         used   mr ex_rd fwd      stall
        vecs[0]  = '{"fwd_dual_s0",  {5'd5, 5'd5}, 2'b01, {5'd0, 5'd5},   0, 10'd0,        2'b00, 0, 5'd0, 4'b0101, 0};
        vecs[1]  = '{"fwd_dual_s1",  {5'd5, 5'd5}, 2'b11, {5'd5, 5'd6},   0, 10'd0,        2'b00, 0, 5'd0, 4'b1010, 0};
        vecs[2]  = '{"fwd_x0",       {5'd0, 5'd0}, 2'b11, {5'd0, 5'd0},   0, 10'd0,        2'b00, 0, 5'd0, 4'b0000, 0};
        vecs[3]  = '{"fwd_priority", {5'd7, 5'd0}, 2'b11, {5'd7, 5'd7},   0, 10'd0,        2'b00, 0, 5'd0, 4'b0100, 0};
        vecs[4]  = '{"fwd_indep",    {5'd4, 5'd3}, 2'b11, {5'd4, 5'd3},   0, 10'd0,        2'b00, 0, 5'd0, 4'b1001, 0};
        vecs[5]  = '{"fwd_we_off",   {5'd5, 5'd5}, 2'b00, {5'd5, 5'd5},   0, 10'd0,        2'b00, 0, 5'd0, 4'b0000, 0};
        vecs[6]  = '{"lu_src1",      10'd0,        2'b00, 10'd0,          1, {5'd3, 5'd1}, 2'b10, 1, 5'd3, 4'b0000, 1};
        vecs[7]  = '{"lu_unused",    10'd0,        2'b00, 10'd0,          1, {5'd3, 5'd1}, 2'b01, 1, 5'd3, 4'b0000, 0};
        vecs[8]  = '{"lu_x0",        10'd0,        2'b00, 10'd0,          1, {5'd0, 5'd0}, 2'b11, 1, 5'd0, 4'b0000, 0};
        vecs[9]  = '{"lu_noval",     10'd0,        2'b00, 10'd0,          0, {5'd3, 5'd3}, 2'b11, 1, 5'd3, 4'b0000, 0};
        vecs[10] = '{"lu_noload",    10'd0,        2'b00, 10'd0,          1, {5'd3, 5'd3}, 2'b11, 0, 5'd3, 4'b0000, 0};
        vecs[11] = '{"lu_src0",      10'd0,        2'b00, 10'd0,          1, {5'd2, 5'd3}, 2'b01, 1, 5'd3, 4'b0000, 1};

        // Reset state: forwarding inputs active but outputs held at zero.
        clear_inputs();
        rst = 1'b1;
        ex_rs = {5'd5, 5'd5}; st_regwrite = 2'b01; st_rd = {5'd0, 5'd5};
        id_valid = 1'b1; id_rs = {5'd3, 5'd3}; id_rs_used = 2'b11; ex_memread = 1'b1; ex_rd = 5'd3;
        #2;
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_timeout", 32'(mc_timeout), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        settle(); settle();
        clear_inputs();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            settle();
            ex_rs = vecs[i].ex_rs; st_regwrite = vecs[i].st_regwrite; st_rd = vecs[i].st_rd;
            id_valid = vecs[i].id_valid; id_rs = vecs[i].id_rs; id_rs_used = vecs[i].id_rs_used;
            ex_memread = vecs[i].ex_memread; ex_rd = vecs[i].ex_rd;
            #1;
            chk({vecs[i].name, "_fwd"}, 32'(fwd_sel), 32'(vecs[i].exp_fwd));
            chk({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].exp_stall));
            chk({vecs[i].name, "_bubble"}, 32'(bubble), 32'(vecs[i].exp_stall));
        end

        // Load-use lasts one cycle: load leaves EX, stall drops.
        settle();
        clear_inputs();
        id_valid = 1'b1; id_rs = {5'd3, 5'd1}; id_rs_used = 2'b10; ex_memread = 1'b1; ex_rd = 5'd3;
        id_mc_issue = 1'b1; id_rd = 5'd8;
        #1 chk("lu_seq_stall", 32'(stall), 32'd1);
        edge_then_sample();
        chk("lu_blocks_issue", 32'(mc_busy), 32'd0);
        settle();
        ex_memread = 1'b0; id_mc_issue = 1'b0;
        #1 chk("lu_seq_release", 32'(stall), 32'd0);

        // mc_done while idle is ignored.
        settle();
        clear_inputs();
        mc_done = 1'b1;
        edge_then_sample();
        chk("done_idle_busy", 32'(mc_busy), 32'd0);

        // Scoreboard: issue divide to x9 at cycle 0, consumer waits until mc_done at cycle 20.
        settle();
        clear_inputs();
        id_valid = 1'b1; id_mc_issue = 1'b1; id_rd = 5'd9;
        #1 chk("sb_issue_stall", 32'(stall), 32'd0);
        edge_then_sample();
        chk("sb_busy", 32'(mc_busy), 32'd1);
        settle();
        id_mc_issue = 1'b0; id_rd = 5'd0; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        #1 chk("sb_raw_stall", 32'(stall), 32'd1);
        chk("sb_raw_bubble", 32'(bubble), 32'd1);
        id_rs_used = 2'b00;
        #1 chk("sb_unused_nostall", 32'(stall), 32'd0);
        id_mc_issue = 1'b1;
        #1 chk("sb_issue2_stall", 32'(stall), 32'd1);
        id_mc_issue = 1'b0; id_rs_used = 2'b01;
        for (int c = 2; c < 20; c++) edge_then_sample();
        chk("sb_c19_stall", 32'(stall), 32'd1);
        settle();
        mc_done = 1'b1;
        #1 chk("sb_done_stall", 32'(stall), 32'd1);
        chk("sb_done_busy", 32'(mc_busy), 32'd1);
        edge_then_sample();
        chk("sb_after_busy", 32'(mc_busy), 32'd0);
        chk("sb_after_stall", 32'(stall), 32'd0);
        chk("sb_no_timeout", 32'(mc_timeout), 32'd0);

        // Timeout: busy for 64 cycles with no mc_done.
        settle();
        clear_inputs();
        id_valid = 1'b1; id_mc_issue = 1'b1; id_rd = 5'd12;
        edge_then_sample();
        settle();
        clear_inputs();
        for (int c = 1; c < 64; c++) edge_then_sample();
        chk("to_c63_busy", 32'(mc_busy), 32'd1);
        chk("to_c63_flag", 32'(mc_timeout), 32'd0);
        edge_then_sample();
        chk("to_c64_busy", 32'(mc_busy), 32'd0);
        chk("to_c64_flag", 32'(mc_timeout), 32'd1);

        // Flag is sticky across a normal op.
        settle();
        id_valid = 1'b1; id_mc_issue = 1'b1; id_rd = 5'd10;
        edge_then_sample();
        settle();
        id_mc_issue = 1'b0; id_rs = {5'd10, 5'd0}; id_rs_used = 2'b10;
        ex_rs = {5'd4, 5'd4}; st_regwrite = 2'b10; st_rd = {5'd4, 5'd0};
        for (int c = 0; c < 3; c++) edge_then_sample();
        chk("sticky_flag", 32'(mc_timeout), 32'd1);
        chk("mid_busy_stall", 32'(stall), 32'd1);
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt == 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_nonzero: got %0h expected nonzero", stall_cnt);
        end else begin
            $display("ok   stall_cnt_nonzero: %0h", stall_cnt);
        end
`endif

        // Asynchronous reset away from any clock edge.
        settle();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(mc_busy), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_bubble", 32'(bubble), 32'd0);
        chk("arst_timeout", 32'(mc_timeout), 32'd0);
        chk("arst_fwd_sel", 32'(fwd_sel), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        chk("arst_stall_cnt", stall_cnt, 32'd0);
`endif
        settle();
        rst = 1'b0;
        #1 chk("post_rst_fwd", 32'(fwd_sel), 32'b1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
